// File: rtl/fsm_arith_unit_pkg.sv
// fsm_arith_unit_pkg: state encodings, mode constants and 7-segment table for the running calculator
package fsm_arith_unit_pkg;
  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_LOAD  = 7'b0000010,
    S_OPER  = 7'b0000100,
    S_MUL   = 7'b0001000,
    S_CHECK = 7'b0010000,
    S_CONV  = 7'b0100000,
    S_ERROR = 7'b1000000
  } state_t;
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_ADD = 1'b1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, SEG_E, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK
  };
  function automatic logic [7:0] seg7(input logic [3:0] d);
    return SEG_TAB[d];
  endfunction
endpackage

// File: rtl/fsm_arith_unit_bcd_serial.sv
// bcd_serial: sequential double-dabble converter, one bit per cycle, start/done handshake
module bcd_serial #(
  parameter int ACC_W = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ACC_W-1:0]      bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(ACC_W + 1);
  logic [ACC_W-1:0] sh, src;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4*DIGITS-1:0] base, adj;
  always_comb begin
    src = start ? bin : sh;
    base = start ? '0 : bcd;
    cnt_nxt = start ? CW'(ACC_W - 1) : cnt - 1'b1;
    adj = base;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = base[4*i+:4] >= 4'd5 ? base[4*i+:4] + 4'd3 : base[4*i+:4];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh <= '0;
      bcd <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || cnt != '0) begin
        {bcd, sh} <= {adj, src} << 1;
        cnt <= cnt_nxt;
        done <= cnt_nxt == '0;
      end
    end
endmodule

// File: rtl/fsm_arith_unit.sv
// fsm_arith_unit: running multiply/add calculator with overflow detection and 7-segment display
module fsm_arith_unit
  import fsm_arith_unit_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int ACC_W = 20,
  parameter int DIGITS = 6,
  parameter int MAX_VAL = 999999,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int ERR_HOLD = 25000000
) (
  input  logic       MAX10_CLK1_50,
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5,
  output logic [9:0] LEDR
);
  localparam int W = ACC_W + DATA_W;
  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int MCW = $clog2(DATA_W + 1);
  localparam int EW = $clog2(ERR_HOLD + 1);
  localparam logic [W-1:0] MAX_W = W'(MAX_VAL);
  logic clk, rst_n, press, db, db_q, conv_go, done, mode, busy;
  logic [1:0] sync;
  logic [DBW-1:0] db_cnt;
  logic [MCW-1:0] mul_cnt;
  logic [EW-1:0] err_cnt;
  logic [DATA_W-1:0] op, mpl;
  logic [ACC_W-1:0] acc;
  logic [W-1:0] wide, mcand;
  logic [4*DIGITS-1:0] bcd;
  logic [23:0] bcd_pad;
  logic [7:0] hex [6];
  logic [7:0] hex_num [6];
  logic [7:0] hex_err [6];
  state_t state;
  assign clk = MAX10_CLK1_50;
  assign rst_n = KEY[1];
  assign op = SW[DATA_W-1:0];
  assign press = db_q & ~db;
  assign bcd_pad = 24'(bcd);
  assign busy = (state == S_MUL) || (state == S_CHECK) || (state == S_CONV);
  assign LEDR = {busy, mode, 1'b0, state};
  assign {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} = {hex[5], hex[4], hex[3], hex[2], hex[1], hex[0]};
  always_comb
    for (int i = 0; i < 6; i++) begin
      hex_num[i] = i < DIGITS ? seg7(bcd_pad[4*i+:4]) : SEG_BLANK;
      hex_err[i] = i < DIGITS ? SEG_E : SEG_BLANK;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= 2'b11;
      db <= 1'b1;
      db_q <= 1'b1;
      db_cnt <= '0;
    end else begin
      sync <= {sync[0], KEY[0]};
      db_q <= db;
      if (sync[1] == db)
        db_cnt <= '0;
      else if (db_cnt == DBW'(DEBOUNCE_CYC - 1)) begin
        db <= sync[1];
        db_cnt <= '0;
      end else
        db_cnt <= db_cnt + 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      mode <= MODE_MUL;
      acc <= '0;
      wide <= '0;
      mcand <= '0;
      mpl <= '0;
      mul_cnt <= '0;
      err_cnt <= '0;
      conv_go <= 1'b0;
      hex <= '{default: SEG_BLANK};
    end else begin
      conv_go <= 1'b0;
      case (state)
        S_IDLE: if (press) begin
          mode <= SW[0];
          acc <= '0;
          state <= S_LOAD;
        end
        S_LOAD: if (press) begin
          acc <= ACC_W'(op);
          conv_go <= 1'b1;
          state <= S_CONV;
        end
        S_OPER: if (press) begin
          mpl <= op;
          mcand <= W'(acc);
          mul_cnt <= '0;
          wide <= mode == MODE_ADD ? W'(acc) + W'(op) : '0;
          state <= mode == MODE_ADD ? S_CHECK : S_MUL;
        end
        S_MUL: begin
          wide <= mpl[0] ? wide + mcand : wide;
          mpl <= mpl >> 1;
          mcand <= mcand << 1;
          mul_cnt <= mul_cnt + 1'b1;
          state <= mul_cnt == MCW'(DATA_W - 1) ? S_CHECK : S_MUL;
        end
        S_CHECK: if (wide > MAX_W) begin
          err_cnt <= '0;
          hex <= hex_err;
          state <= S_ERROR;
        end else begin
          acc <= wide[ACC_W-1:0];
          conv_go <= 1'b1;
          state <= S_CONV;
        end
        S_CONV: if (done) begin
          hex <= hex_num;
          state <= S_OPER;
        end
        S_ERROR: if (err_cnt == EW'(ERR_HOLD - 1)) begin
          acc <= '0;
          hex <= '{default: SEG_BLANK};
          state <= S_IDLE;
        end else
          err_cnt <= err_cnt + 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  bcd_serial #(.ACC_W(ACC_W), .DIGITS(DIGITS)) u_bcd (
    .clk(clk),
    .rst_n(rst_n),
    .start(conv_go),
    .bin(acc),
    .done(done),
    .bcd(bcd)
  );
endmodule

// File: tb/tb_fsm_arith_unit.sv
// tb_fsm_arith_unit: directed self-checking bench for the running calculator
module tb_fsm_arith_unit;
  logic clk = 1'b0;
  logic [1:0] KEY;
  logic [9:0] SW;
  logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;
  logic [47:0] hex_all;
  int checks = 0, failures = 0;
  int busy_run = 0, busy_last = 0, err_run = 0, err_last = 0;
  localparam logic [47:0] ALL_BLANK = {6{8'hFF}};
  localparam logic [47:0] ALL_E = {6{8'h86}};
  fsm_arith_unit #(.DEBOUNCE_CYC(4), .ERR_HOLD(16)) dut (
    .MAX10_CLK1_50(clk),
    .KEY(KEY),
    .SW(SW),
    .HEX0(HEX0),
    .HEX1(HEX1),
    .HEX2(HEX2),
    .HEX3(HEX3),
    .HEX4(HEX4),
    .HEX5(HEX5),
    .LEDR(LEDR)
  );
  always #5 clk = ~clk;
  assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  always @(negedge clk) begin
    if (LEDR[9]) busy_run++;
    else if (busy_run != 0) begin busy_last = busy_run; busy_run = 0; end
    if (LEDR[6]) err_run++;
    else if (err_run != 0) begin err_last = err_run; err_run = 0; end
  end
  function automatic logic [7:0] seg(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction
  function automatic logic [47:0] num_hex(input int n);
    logic [47:0] r;
    int p;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      r[8*i+:8] = seg((n / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction
  task do_reset;
    KEY = 2'b01;
    SW = '0;
    repeat (3) @(negedge clk);
    KEY[1] = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task press_key(input logic [9:0] sw);
    SW = sw;
    KEY[0] = 1'b0;
    repeat (8) @(negedge clk);
    KEY[0] = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  task wait_oper(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = LEDR[2] && !LEDR[9];
    end
    @(negedge clk);
  endtask
  task test_reset;
    KEY = 2'b01;
    SW = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (hex_all !== ALL_BLANK) begin failures++; $display("FAIL reset_hex got=%h exp=%h", hex_all, ALL_BLANK); end
    checks++;
    if (LEDR !== 10'h001) begin failures++; $display("FAIL reset_ledr got=%h exp=%h", LEDR, 10'h001); end
    KEY[1] = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (LEDR !== 10'h001) begin failures++; $display("FAIL idle_stays got=%h exp=%h", LEDR, 10'h001); end
    checks++;
    if (hex_all !== ALL_BLANK) begin failures++; $display("FAIL idle_hex got=%h exp=%h", hex_all, ALL_BLANK); end
  endtask
  task test_mul;
    bit ok;
    do_reset();
    press_key(10'd0);
    checks++;
    if (LEDR !== 10'h002) begin failures++; $display("FAIL mul_load_ledr got=%h exp=%h", LEDR, 10'h002); end
    press_key(10'd12);
    wait_oper(ok);
    checks++;
    if (!ok || busy_last != 21) begin failures++; $display("FAIL load_conv_cycles got=%0d exp=21 ok=%0d", busy_last, ok); end
    checks++;
    if (hex_all !== num_hex(12)) begin failures++; $display("FAIL mul_first got=%h exp=%h", hex_all, num_hex(12)); end
    press_key(10'd34);
    wait_oper(ok);
    checks++;
    if (!ok || busy_last != 32) begin failures++; $display("FAIL mul_latency got=%0d exp=32 ok=%0d", busy_last, ok); end
    checks++;
    if (hex_all !== num_hex(408)) begin failures++; $display("FAIL mul_result got=%h exp=%h", hex_all, num_hex(408)); end
    checks++;
    if (LEDR !== 10'h004) begin failures++; $display("FAIL mul_ledr got=%h exp=%h", LEDR, 10'h004); end
  endtask
  task test_add;
    bit ok;
    do_reset();
    press_key(10'd1);
    checks++;
    if (LEDR !== 10'h102) begin failures++; $display("FAIL add_load_ledr got=%h exp=%h", LEDR, 10'h102); end
    press_key(10'd999);
    wait_oper(ok);
    checks++;
    if (!ok || hex_all !== num_hex(999)) begin failures++; $display("FAIL add_first got=%h exp=%h", hex_all, num_hex(999)); end
    press_key(10'd1);
    wait_oper(ok);
    checks++;
    if (!ok || busy_last != 22) begin failures++; $display("FAIL add_latency got=%0d exp=22 ok=%0d", busy_last, ok); end
    checks++;
    if (hex_all !== num_hex(1000)) begin failures++; $display("FAIL add_result got=%h exp=%h", hex_all, num_hex(1000)); end
    press_key(10'd0);
    wait_oper(ok);
    checks++;
    if (!ok || hex_all !== num_hex(1000)) begin failures++; $display("FAIL add_zero got=%h exp=%h", hex_all, num_hex(1000)); end
    checks++;
    if (LEDR !== 10'h104) begin failures++; $display("FAIL add_ledr got=%h exp=%h", LEDR, 10'h104); end
  endtask
  task test_overflow;
    bit ok;
    do_reset();
    press_key(10'd0);
    press_key(10'd1000);
    wait_oper(ok);
    press_key(10'd1000);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = LEDR[6];
    end
    @(negedge clk);
    checks++;
    if (!ok || hex_all !== ALL_E) begin failures++; $display("FAIL err_hex got=%h exp=%h", hex_all, ALL_E); end
    checks++;
    if (busy_last != 11) begin failures++; $display("FAIL err_entry_cycles got=%0d exp=11", busy_last); end
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = LEDR[0];
    end
    @(negedge clk);
    checks++;
    if (!ok || err_last != 16) begin failures++; $display("FAIL err_hold got=%0d exp=16 ok=%0d", err_last, ok); end
    checks++;
    if (LEDR !== 10'h001) begin failures++; $display("FAIL err_to_idle got=%h exp=%h", LEDR, 10'h001); end
  endtask
  task test_boundary;
    bit ok;
    do_reset();
    press_key(10'd0);
    press_key(10'd999);
    wait_oper(ok);
    press_key(10'd1001);
    wait_oper(ok);
    checks++;
    if (!ok || hex_all !== num_hex(999999)) begin failures++; $display("FAIL max_val got=%h exp=%h", hex_all, num_hex(999999)); end
    SW = 10'd7;
    KEY[0] = 1'b0;
    repeat (2) @(negedge clk);
    KEY[0] = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (LEDR !== 10'h004) begin failures++; $display("FAIL glitch_ledr got=%h exp=%h", LEDR, 10'h004); end
    checks++;
    if (hex_all !== num_hex(999999)) begin failures++; $display("FAIL glitch_hex got=%h exp=%h", hex_all, num_hex(999999)); end
  endtask
  task test_back_to_back;
    bit ok;
    do_reset();
    press_key(10'd0);
    press_key(10'd5);
    wait_oper(ok);
    press_key(10'd3);
    press_key(10'd7);
    wait_oper(ok);
    checks++;
    if (!ok || hex_all !== num_hex(15)) begin failures++; $display("FAIL conv_press got=%h exp=%h", hex_all, num_hex(15)); end
    repeat (20) @(negedge clk);
    checks++;
    if (LEDR !== 10'h004 || hex_all !== num_hex(15)) begin failures++; $display("FAIL press_dropped ledr=%h hex=%h exp_hex=%h", LEDR, hex_all, num_hex(15)); end
    press_key(10'd2);
    wait_oper(ok);
    checks++;
    if (!ok || hex_all !== num_hex(30)) begin failures++; $display("FAIL after_drop got=%h exp=%h", hex_all, num_hex(30)); end
  endtask
  task test_reset_mid_mul;
    bit ok;
    do_reset();
    press_key(10'd0);
    press_key(10'd9);
    wait_oper(ok);
    SW = 10'd3;
    KEY[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = LEDR[3];
    end
    KEY[1] = 1'b0;
    #1;
    checks++;
    if (!ok || LEDR !== 10'h001) begin failures++; $display("FAIL abort_ledr got=%h exp=%h ok=%0d", LEDR, 10'h001, ok); end
    checks++;
    if (hex_all !== ALL_BLANK) begin failures++; $display("FAIL abort_hex got=%h exp=%h", hex_all, ALL_BLANK); end
    @(negedge clk);
    KEY = 2'b11;
    repeat (20) @(negedge clk);
    checks++;
    if (LEDR !== 10'h001 || hex_all !== ALL_BLANK) begin failures++; $display("FAIL post_abort ledr=%h hex=%h", LEDR, hex_all); end
  endtask
  initial begin
    test_reset();
    test_mul();
    test_add();
    test_overflow();
    test_boundary();
    test_back_to_back();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
